score_keeper_bcd: RTL and testbench

//   Parametrised game score keeper. Holds current and high score as packed BCD (DIGITS digits),

---
 rtl/score_keeper_bcd.sv | 193 +++++++++++++++++++
 tb/tb_score_keeper_bcd.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper_bcd.sv
// Game score keeper: binary and packed-BCD current/high score, game-over flash
// sequence and high-score display between games, all outputs registered.
module score_keeper_bcd #(
   parameter int DIGITS       = 3,
   parameter int SCORE_W      = 8,
   parameter int MAX_SCORE    = 140,
   parameter int FLASH_TICKS  = 1000000,
   parameter int FLASH_HALVES = 8
) (
   input  logic                  clk,
   input  logic                  nRst,
   input  logic                  goodColl,
   input  logic                  badColl,
   input  logic                  clearHigh,
   output logic [SCORE_W-1:0]    score,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic [4*DIGITS-1:0]   high_bcd,
   output logic [4*DIGITS-1:0]   disp_bcd,
   output logic                  disp_on,
   output logic                  isGameComplete,
   output logic                  win
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int TICK_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
   localparam int HALF_W = (FLASH_HALVES > 1) ? $clog2(FLASH_HALVES) : 1;

   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(FLASH_TICKS - 1);
   localparam logic [HALF_W-1:0]  HALF_LAST = HALF_W'(FLASH_HALVES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(MAX_SCORE);

   localparam logic [1:0] ST_PLAY      = 2'd0;
   localparam logic [1:0] ST_FLASH     = 2'd1;
   localparam logic [1:0] ST_SHOW_HIGH = 2'd2;

   logic [1:0]         state_q,         state_d;
   logic [SCORE_W-1:0] score_q,         score_d;
   logic [BCD_W-1:0]   score_bcd_q,     score_bcd_d;
   logic [SCORE_W-1:0] high_q,          high_d;
   logic [BCD_W-1:0]   high_bcd_q,      high_bcd_d;
   logic [BCD_W-1:0]   disp_bcd_q,      disp_bcd_d;
   logic               disp_on_q,       disp_on_d;
   logic               game_complete_q, game_complete_d;
   logic               win_q,           win_d;
   logic [TICK_W-1:0]  tick_q,          tick_d;
   logic [HALF_W-1:0]  half_q,          half_d;

   logic [SCORE_W-1:0] score_inc;
   logic [BCD_W-1:0]   score_bcd_inc;

   // Decimal increment by a ripple of per-digit carries; no division needed.
   function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] value);
      logic [BCD_W-1:0] result;
      logic             carry;
      result = value;
      carry  = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (value[4*i +: 4] == 4'd9) begin
               result[4*i +: 4] = 4'd0;
            end else begin
               result[4*i +: 4] = value[4*i +: 4] + 4'd1;
               carry            = 1'b0;
            end
         end
      end
      return result;
   endfunction

   assign score_inc     = score_q + SCORE_W'(1);
   assign score_bcd_inc = bcd_inc(score_bcd_q);

   always_comb begin
      state_d     = state_q;
      score_d     = score_q;
      score_bcd_d = score_bcd_q;
      high_d      = high_q;
      high_bcd_d  = high_bcd_q;
      disp_on_d   = disp_on_q;
      win_d       = win_q;
      tick_d      = tick_q;
      half_d      = half_q;

      case (state_q)
         ST_PLAY: begin
            if (badColl) begin
               state_d   = ST_FLASH;
               win_d     = 1'b0;
               disp_on_d = 1'b0;
               tick_d    = '0;
               half_d    = '0;
               if (score_q > high_q) begin
                  high_d     = score_q;
                  high_bcd_d = score_bcd_q;
               end
            end else if (goodColl) begin
               score_d     = score_inc;
               score_bcd_d = score_bcd_inc;
               // Reaching the maximum ends the game on the same edge as the increment.
               if (score_inc == SCORE_MAX) begin
                  state_d   = ST_FLASH;
                  win_d     = 1'b1;
                  disp_on_d = 1'b0;
                  tick_d    = '0;
                  half_d    = '0;
                  if (score_inc > high_q) begin
                     high_d     = score_inc;
                     high_bcd_d = score_bcd_inc;
                  end
               end
            end
         end

         ST_FLASH: begin
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if (half_q == HALF_LAST) begin
                  state_d   = ST_SHOW_HIGH;
                  disp_on_d = 1'b1;
                  half_d    = '0;
               end else begin
                  half_d    = half_q + HALF_W'(1);
                  disp_on_d = ~disp_on_q;
               end
            end else begin
               tick_d = tick_q + TICK_W'(1);
            end
         end

         ST_SHOW_HIGH: begin
            disp_on_d = 1'b1;
            if (clearHigh) begin
               high_d     = '0;
               high_bcd_d = '0;
            end
            if (goodColl) begin
               state_d     = ST_PLAY;
               score_d     = '0;
               score_bcd_d = '0;
               win_d       = 1'b0;
               tick_d      = '0;
               half_d      = '0;
            end
         end

         default: begin
            state_d   = ST_PLAY;
            disp_on_d = 1'b1;
         end
      endcase

      // Display source follows the next state so it stays aligned with the score registers.
      game_complete_d = (state_d != ST_PLAY);
      disp_bcd_d      = (state_d == ST_SHOW_HIGH) ? high_bcd_d : score_bcd_d;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q         <= ST_PLAY;
         score_q         <= '0;
         score_bcd_q     <= '0;
         high_q          <= '0;
         high_bcd_q      <= '0;
         disp_bcd_q      <= '0;
         disp_on_q       <= 1'b1;
         game_complete_q <= 1'b0;
         win_q           <= 1'b0;
         tick_q          <= '0;
         half_q          <= '0;
      end else begin
         state_q         <= state_d;
         score_q         <= score_d;
         score_bcd_q     <= score_bcd_d;
         high_q          <= high_d;
         high_bcd_q      <= high_bcd_d;
         disp_bcd_q      <= disp_bcd_d;
         disp_on_q       <= disp_on_d;
         game_complete_q <= game_complete_d;
         win_q           <= win_d;
         tick_q          <= tick_d;
         half_q          <= half_d;
      end
   end

   assign score          = score_q;
   assign score_bcd      = score_bcd_q;
   assign high_bcd       = high_bcd_q;
   assign disp_bcd       = disp_bcd_q;
   assign disp_on        = disp_on_q;
   assign isGameComplete = game_complete_q;
   assign win            = win_q;

endmodule

// File: tb/tb_score_keeper_bcd.sv
// Self-checking bench for score_keeper_bcd: table vectors, directed game sequences
// and random stimulus compared against a cycle-level behavioural game model.
module tb_score_keeper_bcd;

   localparam int DIGITS    = 3;
   localparam int SCORE_W   = 8;
   localparam int MAX_SCORE = 140;
   localparam int FT        = 4;
   localparam int FH        = 8;
   localparam int BCD_W     = 4 * DIGITS;

   logic               clk = 1'b0;
   logic               nRst;
   logic               goodColl;
   logic               badColl;
   logic               clearHigh;
   logic [SCORE_W-1:0] score;
   logic [BCD_W-1:0]   score_bcd;
   logic [BCD_W-1:0]   high_bcd;
   logic [BCD_W-1:0]   disp_bcd;
   logic               disp_on;
   logic               isGameComplete;
   logic               win;

   int errors = 0;
   int checks = 0;

   // Behavioural model: game phase, plain integer scores, cycles elapsed in the flash.
   int m_phase;
   int m_score;
   int m_high;
   int m_elapsed;
   int m_win;

   localparam int PH_PLAY  = 0;
   localparam int PH_FLASH = 1;
   localparam int PH_SHOW  = 2;

   score_keeper_bcd #(
      .DIGITS(DIGITS), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE),
      .FLASH_TICKS(FT), .FLASH_HALVES(FH)
   ) dut (
      .clk(clk), .nRst(nRst), .goodColl(goodColl), .badColl(badColl),
      .clearHigh(clearHigh), .score(score), .score_bcd(score_bcd),
      .high_bcd(high_bcd), .disp_bcd(disp_bcd), .disp_on(disp_on),
      .isGameComplete(isGameComplete), .win(win)
   );

   always #5 clk = ~clk;

   function automatic int to_bcd(input int value);
      int result;
      result = 0;
      for (int i = 0; i < DIGITS; i++)
         result += ((value / (10 ** i)) % 10) << (4 * i);
      return result;
   endfunction

   task automatic modelReset();
      m_phase   = PH_PLAY;
      m_score   = 0;
      m_high    = 0;
      m_elapsed = 0;
      m_win     = 0;
   endtask

   task automatic enterFlash(input int won);
      if (m_score > m_high) m_high = m_score;
      m_phase   = PH_FLASH;
      m_win     = won;
      m_elapsed = 0;
   endtask

   task automatic modelStep(input bit g, input bit b, input bit c);
      case (m_phase)
         PH_PLAY: begin
            if (b) enterFlash(0);
            else if (g) begin
               m_score++;
               if (m_score == MAX_SCORE) enterFlash(1);
            end
         end
         PH_FLASH: begin
            m_elapsed++;
            if (m_elapsed == FT * FH) m_phase = PH_SHOW;
         end
         default: begin
            if (c) m_high = 0;
            if (g) begin
               m_phase = PH_PLAY;
               m_score = 0;
               m_win   = 0;
            end
         end
      endcase
   endtask

   task automatic checkField(input string name, input int actual, input int required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
      end
   endtask

   task automatic checkOutput(input string tag);
      int exp_disp_on;
      exp_disp_on = (m_phase == PH_FLASH) ? ((m_elapsed / FT) % 2) : 1;
      checkField({tag, " score"},     int'(score),     m_score);
      checkField({tag, " score_bcd"}, int'(score_bcd), to_bcd(m_score));
      checkField({tag, " high_bcd"},  int'(high_bcd),  to_bcd(m_high));
      checkField({tag, " disp_bcd"},  int'(disp_bcd),
                 (m_phase == PH_SHOW) ? to_bcd(m_high) : to_bcd(m_score));
      checkField({tag, " disp_on"},   int'(disp_on),   exp_disp_on);
      checkField({tag, " complete"},  int'(isGameComplete), int'(m_phase != PH_PLAY));
      checkField({tag, " win"},       int'(win),       m_win);
   endtask

   task automatic applyStimulus(input bit g, input bit b, input bit c);
      @(negedge clk);
      goodColl  = g;
      badColl   = b;
      clearHigh = c;
      @(posedge clk);
      modelStep(g, b, c);
      #1;
   endtask

   task automatic doReset();
      nRst      = 1'b0;
      goodColl  = 1'b0;
      badColl   = 1'b0;
      clearHigh = 1'b0;
      #1;
      modelReset();
      checkOutput("reset");
      @(negedge clk);
      nRst = 1'b1;
   endtask

   task automatic pulses(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput(tag);
      end
   endtask

   task automatic waitShow(input string tag);
      for (int i = 0; i < 100 && m_phase != PH_SHOW; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput(tag);
      end
      checkField({tag, " reached show"}, int'(m_phase == PH_SHOW), 1);
   endtask

   typedef struct {
      bit g;
      bit b;
      bit c;
      int exp_score;
      int exp_bcd;
      bit exp_complete;
      bit exp_disp_on;
   } vec_t;

   vec_t tbl[8];

   initial begin
      tbl[0] = '{1, 0, 0, 1, 'h001, 0, 1};
      tbl[1] = '{0, 0, 0, 1, 'h001, 0, 1};
      tbl[2] = '{1, 0, 0, 2, 'h002, 0, 1};
      tbl[3] = '{0, 0, 1, 2, 'h002, 0, 1};
      tbl[4] = '{1, 1, 0, 2, 'h002, 1, 0};
      tbl[5] = '{1, 0, 0, 2, 'h002, 1, 0};
      tbl[6] = '{0, 1, 0, 2, 'h002, 1, 0};
      tbl[7] = '{0, 0, 1, 2, 'h002, 1, 0};

      nRst      = 1'b1;
      goodColl  = 1'b0;
      badColl   = 1'b0;
      clearHigh = 1'b0;
      #3;
      doReset();
      checkField("reset disp_on", int'(disp_on), 1);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(tbl[i].g, tbl[i].b, tbl[i].c);
         checkOutput("tbl");
         checkField("tbl score",    int'(score),          tbl[i].exp_score);
         checkField("tbl bcd",      int'(score_bcd),      tbl[i].exp_bcd);
         checkField("tbl complete", int'(isGameComplete), int'(tbl[i].exp_complete));
         checkField("tbl disp_on",  int'(disp_on),        int'(tbl[i].exp_disp_on));
      end
      waitShow("tbl flash");
      checkField("tbl high", int'(high_bcd), 'h002);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("tbl restart");

      // Carry through one and then two digits.
      doReset();
      pulses(19, "count");
      checkField("count19 bcd", int'(score_bcd), 'h019);
      pulses(1, "count");
      checkField("count20 bcd", int'(score_bcd), 'h020);
      pulses(79, "count");
      checkField("count99 bcd", int'(score_bcd), 'h099);
      pulses(1, "count");
      checkField("count100 bcd", int'(score_bcd), 'h100);
      checkField("count100 disp", int'(disp_bcd), 'h100);

      // Loss at score 5: flash timing and high-score display.
      doReset();
      pulses(5, "lose");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("lose entry");
      checkField("lose complete", int'(isGameComplete), 1);
      checkField("lose disp_on0", int'(disp_on), 0);
      for (int i = 1; i < FT * FH; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("lose flash");
         checkField("lose disp_on", int'(disp_on), (i / FT) % 2);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("lose show");
      checkField("lose disp_bcd", int'(disp_bcd), 'h005);
      checkField("lose high_bcd", int'(high_bcd), 'h005);
      checkField("lose show on",  int'(disp_on), 1);

      // Simultaneous good and bad collision: no increment, loss.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("both restart");
      pulses(7, "both");
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("both");
      checkField("both score", int'(score), 7);
      checkField("both win", int'(win), 0);
      checkField("both complete", int'(isGameComplete), 1);
      waitShow("both flash");
      checkField("both high", int'(high_bcd), 'h007);

      // Win at the maximum score, extra pulses ignored.
      doReset();
      pulses(MAX_SCORE, "winrun");
      checkField("win flag", int'(win), 1);
      checkField("win score", int'(score_bcd), 'h140);
      checkField("win high", int'(high_bcd), 'h140);
      pulses(5, "win extra");
      checkField("win capped", int'(score), MAX_SCORE);
      waitShow("win flash");

      // Clearing the high score, then a short game and a combined clear+restart.
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("clear");
      checkField("clear high", int'(high_bcd), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("clear restart");
      pulses(12, "twelve");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("twelve end");
      waitShow("twelve flash");
      checkField("twelve high", int'(high_bcd), 'h012);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("clear+go");
      checkField("clear+go score", int'(score), 0);
      checkField("clear+go high", int'(high_bcd), 0);

      // Asynchronous reset in the middle of a flash.
      pulses(3, "midrst");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("midrst");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         checkOutput("midrst flash");
      end
      @(negedge clk);
      #2;
      doReset();
      checkField("midrst complete", int'(isGameComplete), 0);

      // Random play with occasional resets.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(2999) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(2) == 0, $urandom_range(199) == 0,
                          $urandom_range(29) == 0);
            checkOutput("rand");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
